// File: rtl/rs_pkg.sv
// rs_pkg: link-fault encodings and sequencer states, shared by the RX and TX reconciliation sublayers.
package rs_pkg;
    localparam logic [1:0] LINK_OK     = 2'b00;
    localparam logic [1:0] LINK_LOCAL  = 2'b01;
    localparam logic [1:0] LINK_REMOTE = 2'b10;
    typedef enum logic [1:0] {IDLE, COUNT, FAULT} state_t;
endpackage

// File: rtl/rx_link_fault_ctrl.sv
// rx_link_fault_ctrl: qualifies RX local/remote fault sequences into link_fault and TX/RX RS controls.
// Define LF_STATS_EN to add saturating lf_events/rf_events entry counters.
module rx_link_fault_ctrl
    import rs_pkg::*;
#(
    parameter int SEQ_THRESH = 4,
    parameter int COL_WINDOW = 128,
    parameter int CNT_W      = 8
) (
    input  logic        rxclk,
    input  logic        reset,
    input  logic        col_tick,
    input  logic        local_fault,
    input  logic        remote_fault,
    input  logic        stats_clr,
    output logic [1:0]  link_fault,
    output logic        tx_send_rf,
    output logic        tx_send_idle,
    output logic        rx_gate,
    output logic        fault_change,
    output logic [15:0] lf_events,
    output logic [15:0] rf_events
);
    localparam int SW = $clog2(SEQ_THRESH + 1);
    localparam logic [SW-1:0] THR = SW'(SEQ_THRESH);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(COL_WINDOW - 1);

    state_t            state, state_n;
    logic [SW-1:0]     seq_cnt, seq_n;
    logic [CNT_W-1:0]  col_cnt, col_n;
    logic [1:0]        last_type, last_n, lf_n;
    logic              seq, clean, win, same;
    logic [1:0]        t;

    // Simultaneous local and remote detections resolve to LOCAL.
    assign seq   = col_tick & (local_fault | remote_fault);
    assign clean = col_tick & ~seq;
    assign t     = local_fault ? LINK_LOCAL : LINK_REMOTE;
    assign win   = col_cnt == WIN_LAST;
    assign same  = t == last_type;

    always_comb begin
        state_n = state;
        seq_n   = seq_cnt;
        col_n   = col_cnt;
        last_n  = last_type;
        lf_n    = link_fault;
        case (state)
            IDLE: if (seq) begin
                last_n  = t;
                seq_n   = SW'(1);
                col_n   = '0;
                state_n = COUNT;
            end
            COUNT: if (seq) begin
                col_n = '0;
                if (same) begin
                    seq_n = seq_cnt + 1'b1;
                    if (seq_cnt + 1'b1 == THR) begin
                        lf_n    = t;
                        state_n = FAULT;
                    end
                end else begin
                    last_n = t;
                    seq_n  = SW'(1);
                end
            end else if (clean) begin
                if (win) begin
                    seq_n   = '0;
                    col_n   = '0;
                    state_n = IDLE;
                end else col_n = col_cnt + 1'b1;
            end
            FAULT: if (seq) begin
                col_n = '0;
                if (!same) begin
                    last_n = t;
                    seq_n  = SW'(1);
                end else if (seq_cnt != THR) begin
                    seq_n = seq_cnt + 1'b1;
                    if (seq_cnt + 1'b1 == THR) lf_n = t;
                end
            end else if (clean) begin
                if (win) begin
                    lf_n    = LINK_OK;
                    seq_n   = '0;
                    col_n   = '0;
                    state_n = IDLE;
                end else col_n = col_cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge rxclk) begin
        if (reset) begin
            state        <= IDLE;
            seq_cnt      <= '0;
            col_cnt      <= '0;
            last_type    <= LINK_LOCAL;
            link_fault   <= LINK_OK;
            fault_change <= 1'b0;
        end else begin
            state        <= state_n;
            seq_cnt      <= seq_n;
            col_cnt      <= col_n;
            last_type    <= last_n;
            link_fault   <= lf_n;
            fault_change <= lf_n != link_fault;
        end
    end

    always_comb begin
        tx_send_rf   = link_fault == LINK_LOCAL;
        tx_send_idle = link_fault == LINK_REMOTE;
        rx_gate      = link_fault != LINK_OK;
    end

`ifdef LF_STATS_EN
    always_ff @(posedge rxclk) begin
        if (reset || stats_clr) begin
            lf_events <= '0;
            rf_events <= '0;
        end else begin
            if (lf_n == LINK_LOCAL && link_fault != LINK_LOCAL && lf_events != 16'hFFFF)
                lf_events <= lf_events + 1'b1;
            if (lf_n == LINK_REMOTE && link_fault != LINK_REMOTE && rf_events != 16'hFFFF)
                rf_events <= rf_events + 1'b1;
        end
    end
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign lf_events = '0;
    assign rf_events = '0;
`endif
endmodule

// File: tb/tb_rx_link_fault_ctrl.sv
// tb_rx_link_fault_ctrl: directed checks of fault qualification, clearing, reset and optional statistics.
module tb_rx_link_fault_ctrl;
    import rs_pkg::*;

    logic        rxclk = 1'b0;
    logic        reset = 1'b0;
    logic        col_tick = 1'b0;
    logic        local_fault = 1'b0;
    logic        remote_fault = 1'b0;
    logic        stats_clr = 1'b0;
    logic [1:0]  link_fault;
    logic        tx_send_rf, tx_send_idle, rx_gate, fault_change;
    logic [15:0] lf_events, rf_events;
    int total = 0;
    int bad = 0;

    rx_link_fault_ctrl dut (
        .rxclk(rxclk), .reset(reset), .col_tick(col_tick),
        .local_fault(local_fault), .remote_fault(remote_fault), .stats_clr(stats_clr),
        .link_fault(link_fault), .tx_send_rf(tx_send_rf), .tx_send_idle(tx_send_idle),
        .rx_gate(rx_gate), .fault_change(fault_change),
        .lf_events(lf_events), .rf_events(rf_events)
    );

    always #5 rxclk = ~rxclk;

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge that consumed them.
    task automatic cyc(input logic tk, input logic lf, input logic rf);
        col_tick = tk;
        local_fault = lf;
        remote_fault = rf;
        @(posedge rxclk);
        #1;
        col_tick = 1'b0;
        local_fault = 1'b0;
        remote_fault = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic cleans(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (link_fault !== 2'b00 || tx_send_rf !== 1'b0 || tx_send_idle !== 1'b0 || rx_gate !== 1'b0 || fault_change !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got lf=%b rf=%b idle=%b gate=%b chg=%b exp all 0", link_fault, tx_send_rf, tx_send_idle, rx_gate, fault_change);
        end
        total++;
        if (lf_events !== 16'h0 || rf_events !== 16'h0) begin
            bad++;
            $display("FAIL reset_stats got lf=%h rf=%h exp 0", lf_events, rf_events);
        end
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0);
        do_reset();
        total++;
        if (link_fault !== 2'b00 || fault_change !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_fault got lf=%b chg=%b exp 00/0", link_fault, fault_change);
        end
    endtask

    task automatic test_local_qualify();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 1'b1, 1'b0);
            if (k < 4) begin
                total++;
                if (link_fault !== 2'b00) begin
                    bad++;
                    $display("FAIL lf_early k=%0d got=%b exp=00", k, link_fault);
                end
                cleans(10);
            end
        end
        total++;
        if (link_fault !== 2'b01 || tx_send_rf !== 1'b1 || rx_gate !== 1'b1 || tx_send_idle !== 1'b0 || fault_change !== 1'b1) begin
            bad++;
            $display("FAIL lf_declare got lf=%b rf=%b gate=%b idle=%b chg=%b exp 01/1/1/0/1", link_fault, tx_send_rf, rx_gate, tx_send_idle, fault_change);
        end
        cleans(1);
        total++;
        if (fault_change !== 1'b0 || link_fault !== 2'b01) begin
            bad++;
            $display("FAIL lf_pulse_once got lf=%b chg=%b exp 01/0", link_fault, fault_change);
        end
    endtask

    task automatic test_window_no_fault();
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
        cleans(127);
        total++;
        if (dut.state !== COUNT || link_fault !== 2'b00) begin
            bad++;
            $display("FAIL win127 got state=%0d lf=%b exp COUNT/00", dut.state, link_fault);
        end
        cleans(1);
        total++;
        if (dut.state !== IDLE || link_fault !== 2'b00 || fault_change !== 1'b0) begin
            bad++;
            $display("FAIL win128 got state=%0d lf=%b chg=%b exp IDLE/00/0", dut.state, link_fault, fault_change);
        end
    endtask

    task automatic test_type_switch();
        do_reset();
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 1'b0, 1'b1);
            if (k < 4) begin
                total++;
                if (link_fault !== 2'b00) begin
                    bad++;
                    $display("FAIL rf_early k=%0d got=%b exp=00", k, link_fault);
                end
            end
        end
        total++;
        if (link_fault !== 2'b10 || tx_send_idle !== 1'b1 || tx_send_rf !== 1'b0 || rx_gate !== 1'b1 || fault_change !== 1'b1) begin
            bad++;
            $display("FAIL rf_declare got lf=%b idle=%b rf=%b gate=%b chg=%b exp 10/1/0/1/1", link_fault, tx_send_idle, tx_send_rf, rx_gate, fault_change);
        end
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 1'b1, 1'b1);
            total++;
            if (link_fault !== (k < 4 ? 2'b10 : 2'b01) || fault_change !== (k == 4)) begin
                bad++;
                $display("FAIL fault_switch k=%0d got lf=%b chg=%b exp %b/%b", k, link_fault, fault_change, (k < 4 ? 2'b10 : 2'b01), (k == 4));
            end
        end
    endtask

    task automatic test_fault_clear();
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0);
        cleans(127);
        total++;
        if (link_fault !== 2'b01) begin
            bad++;
            $display("FAIL clr127 got=%b exp=01", link_fault);
        end
        cleans(1);
        total++;
        if (link_fault !== 2'b00 || fault_change !== 1'b1 || rx_gate !== 1'b0 || tx_send_rf !== 1'b0) begin
            bad++;
            $display("FAIL clr128 got lf=%b chg=%b gate=%b rf=%b exp 00/1/0/0", link_fault, fault_change, rx_gate, tx_send_rf);
        end
    endtask

    task automatic test_reset_restart();
        do_reset();
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        total++;
        if (link_fault !== 2'b00) begin
            bad++;
            $display("FAIL restart_two got=%b exp=00", link_fault);
        end
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        total++;
        if (link_fault !== 2'b01) begin
            bad++;
            $display("FAIL restart_four got=%b exp=01", link_fault);
        end
    endtask

`ifdef LF_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0);
            cleans(128);
        end
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1);
        total++;
        if (lf_events !== 16'd3 || rf_events !== 16'd1) begin
            bad++;
            $display("FAIL stats_count got lf=%0d rf=%0d exp 3/1", lf_events, rf_events);
        end
        stats_clr = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        stats_clr = 1'b0;
        total++;
        if (lf_events !== 16'd0 || rf_events !== 16'd0) begin
            bad++;
            $display("FAIL stats_clr got lf=%0d rf=%0d exp 0/0", lf_events, rf_events);
        end
        force dut.lf_events = 16'hFFFF;
        #1;
        release dut.lf_events;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0);
        total++;
        if (link_fault !== 2'b01 || lf_events !== 16'hFFFF) begin
            bad++;
            $display("FAIL stats_sat got lf=%b ev=%h exp 01/FFFF", link_fault, lf_events);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_local_qualify();
        test_window_no_fault();
        test_type_switch();
        test_fault_clear();
        test_reset_restart();
`ifdef LF_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
